// File: rtl/drive_pkg.sv
// Shared definitions for the IR drive command stage.
//   - state_t      : drive FSM states
//   - KEY_*        : IR key codes carried in frame bits [23:16]
//   - CMD_*        : one-hot commands understood by the motor controller
//   - MS_*         : encoded drive state reported in the status byte
//   - make_stat()  : builds the status byte sent toward the UART
package drive_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    localparam logic [7:0] KEY_FWD   = 8'h02;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_BRAKE = 8'h05;
    localparam logic [7:0] KEY_RIGHT = 8'h06;
    localparam logic [7:0] KEY_BACK  = 8'h08;

    localparam logic [7:0] CMD_NONE  = 8'h00;
    localparam logic [7:0] CMD_FWD   = 8'h02;
    localparam logic [7:0] CMD_LEFT  = 8'h08;
    localparam logic [7:0] CMD_BRAKE = 8'h10;
    localparam logic [7:0] CMD_RIGHT = 8'h20;
    localparam logic [7:0] CMD_BACK  = 8'h80;

    localparam logic [2:0] MS_IDLE  = 3'd0;
    localparam logic [2:0] MS_FWD   = 3'd1;
    localparam logic [2:0] MS_LEFT  = 3'd2;
    localparam logic [2:0] MS_BRAKE = 3'd3;
    localparam logic [2:0] MS_RIGHT = 3'd4;
    localparam logic [2:0] MS_BACK  = 3'd5;

    // Bit 0 is always set so that no real status equals the reset
    // value of the sender's last_sent register.
    function automatic logic [7:0] make_stat(input logic [3:0] prox,
                                             input logic [2:0] mstat);
        return {prox, mstat, 1'b1};
    endfunction

endpackage

// File: rtl/status_sender.sv
// Change-driven status sender with a valid/ready output.
// Whenever the idle sender sees a status different from the last one
// delivered, it captures it and offers it until accepted.
//   clk, rst : clock, synchronous active-high reset
//   status   : current status (live)
//   ready    : consumer accepts the offered word
//   data     : captured word, stable while valid && !ready
//   valid    : data is being offered
module status_sender #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] status,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid
);

    logic [W-1:0] last_sent;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_sent <= '0;
            data      <= '0;
            valid     <= 1'b0;
        end else if (valid) begin
            if (ready) begin
                last_sent <= data;
                valid     <= 1'b0;
            end
        end else if (status != last_sent) begin
            // Intermediate changes while an offer is pending are not
            // queued; the newest status is picked up once idle again.
            data  <= status;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ir_drive_cmd.sv
// IR drive command stage: validates decoded IR frames, maps keys to the
// one-hot motor command, holds it for HOLD_MS after the last valid frame,
// vetoes forward motion when an obstacle is near, and reports every
// drive/proximity status change to the UART via status_sender.
//   clk, rst    : clock, synchronous active-high reset
//   ir_valid    : one-cycle pulse, ir_data holds a new frame
//   ir_data     : frame, [23:16] key, [31:24] complement of key
//   prox_level  : obstacle distance, 0 nearest .. 15 far
//   cmd         : registered one-hot drive command
//   motor_stat  : registered encoded drive state
//   stat_byte   : {prox_level, motor_stat, 1} as captured
//   stat_valid  : stat_byte offered, stat_ready accepts it
//   err_cnt     : saturating count of frames failing the complement check
module ir_drive_cmd
    import drive_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int HOLD_MS  = 150,
    parameter int PROX_MIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_valid,
    input  logic [31:0] ir_data,
    input  logic [3:0]  prox_level,
    output logic [7:0]  cmd,
    output logic [2:0]  motor_stat,
    output logic [7:0]  stat_byte,
    output logic        stat_valid,
    input  logic        stat_ready,
    output logic [7:0]  err_cnt
);

    localparam int HOLD_CYCLES     = CLK_HZ / 1000 * HOLD_MS;
    localparam int TW              = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD = TW'(HOLD_CYCLES);
    localparam logic [3:0] PROX_TH = 4'(PROX_MIN);

    state_t        state;
    logic [TW-1:0] timer;
    logic          fwd_lat;     // latched key is forward (veto applies)

    logic [7:0]    key;
    logic          frame_ok;
    logic          too_near;
    logic          key_hit;
    logic [7:0]    key_cmd;
    logic [2:0]    key_ms;
    logic          unused_low;

    assign key        = ir_data[23:16];
    assign frame_ok   = (ir_data[31:24] == ~key);
    assign too_near   = (prox_level <= PROX_TH);
    assign unused_low = ^ir_data[15:0];

    always_comb begin
        key_hit = 1'b1;
        key_cmd = CMD_NONE;
        key_ms  = MS_IDLE;
        case (key)
            KEY_FWD:   begin key_cmd = CMD_FWD;   key_ms = MS_FWD;   end
            KEY_LEFT:  begin key_cmd = CMD_LEFT;  key_ms = MS_LEFT;  end
            KEY_BRAKE: begin key_cmd = CMD_BRAKE; key_ms = MS_BRAKE; end
            KEY_RIGHT: begin key_cmd = CMD_RIGHT; key_ms = MS_RIGHT; end
            KEY_BACK:  begin key_cmd = CMD_BACK;  key_ms = MS_BACK;  end
            default:   key_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd        <= CMD_NONE;
            motor_stat <= MS_IDLE;
            timer      <= '0;
            fwd_lat    <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            if (ir_valid && !frame_ok && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;

            if (ir_valid && frame_ok) begin
                // A valid frame overrides expiry and the proximity rules;
                // its own veto uses the prox_level of this same cycle.
                if (!key_hit) begin
                    state      <= IDLE;
                    cmd        <= CMD_NONE;
                    motor_stat <= MS_IDLE;
                    timer      <= '0;
                    fwd_lat    <= 1'b0;
                end else begin
                    timer   <= HOLD;
                    fwd_lat <= (key == KEY_FWD);
                    if (key == KEY_FWD && too_near) begin
                        state      <= BLOCKED;
                        cmd        <= CMD_BRAKE;
                        motor_stat <= MS_BRAKE;
                    end else begin
                        state      <= DRIVE;
                        cmd        <= key_cmd;
                        motor_stat <= key_ms;
                    end
                end
            end else begin
                case (state)
                    IDLE: ;
                    DRIVE, BLOCKED: begin
                        timer <= timer - TW'(1);
                        // Timer reaching 0 on this edge ends the hold, so
                        // the drive lasts exactly HOLD_CYCLES cycles.
                        if (timer <= TW'(1)) begin
                            state      <= IDLE;
                            cmd        <= CMD_NONE;
                            motor_stat <= MS_IDLE;
                            timer      <= '0;
                        end else if (state == DRIVE && fwd_lat && too_near) begin
                            state      <= BLOCKED;
                            cmd        <= CMD_BRAKE;
                            motor_stat <= MS_BRAKE;
                        end else if (state == BLOCKED && !too_near) begin
                            state      <= DRIVE;
                            cmd        <= CMD_FWD;
                            motor_stat <= MS_FWD;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        cmd        <= CMD_NONE;
                        motor_stat <= MS_IDLE;
                        timer      <= '0;
                    end
                endcase
            end
        end
    end

    status_sender #(.W(8)) u_sender (
        .clk    (clk),
        .rst    (rst),
        .status (make_stat(prox_level, motor_stat)),
        .ready  (stat_ready),
        .data   (stat_byte),
        .valid  (stat_valid)
    );

endmodule

// File: tb/tb_ir_drive_cmd.sv
// Self-checking bench for ir_drive_cmd. Expected commands and status bytes
// are pushed to queues when stimulus is applied and popped when the DUT
// output is sampled (on the falling edge).
module tb_ir_drive_cmd;

    localparam int CLK_HZ   = 10_000_000;
    localparam int HOLD_MS  = 1;
    localparam int PROX_MIN = 2;
    localparam int HOLD     = CLK_HZ / 1000 * HOLD_MS;   // 10000 cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ir_valid = 1'b0;
    logic [31:0] ir_data = '0;
    logic [3:0]  prox_level = 4'd9;
    logic [7:0]  cmd;
    logic [2:0]  motor_stat;
    logic [7:0]  stat_byte;
    logic        stat_valid;
    logic        stat_ready = 1'b0;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    logic [10:0] cmd_q[$];   // {cmd, motor_stat}
    logic [7:0]  stat_q[$];

    ir_drive_cmd #(.CLK_HZ(CLK_HZ), .HOLD_MS(HOLD_MS), .PROX_MIN(PROX_MIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .ir_valid   (ir_valid),
        .ir_data    (ir_data),
        .prox_level (prox_level),
        .cmd        (cmd),
        .motor_stat (motor_stat),
        .stat_byte  (stat_byte),
        .stat_valid (stat_valid),
        .stat_ready (stat_ready),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] model(input logic [7:0] key, input logic [3:0] prox);
        case (key)
            8'h02:   return (prox <= 4'(PROX_MIN)) ? {8'h10, 3'd3} : {8'h02, 3'd1};
            8'h04:   return {8'h08, 3'd2};
            8'h05:   return {8'h10, 3'd3};
            8'h06:   return {8'h20, 3'd4};
            8'h08:   return {8'h80, 3'd5};
            default: return {8'h00, 3'd0};
        endcase
    endfunction

    // Called on a falling edge; returns on the falling edge after the
    // sampling edge. Valid frames push their expected result.
    task automatic send_frame(input logic [7:0] comp, input logic [7:0] key);
        ir_data  = {comp, key, 16'($urandom)};
        ir_valid = 1'b1;
        if (comp == ~key) cmd_q.push_back(model(key, prox_level));
        @(negedge clk);
        ir_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst = 1'b1; stat_ready = 1'b0; prox_level = 4'd9;
        repeat (3) @(negedge clk);
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %h want 00", cmd); end
        checks++; if (motor_stat !== 3'd0) begin errors++; $display("FAIL reset_mstat: got %0d want 0", motor_stat); end
        checks++; if (stat_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", stat_valid); end
        checks++; if (stat_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", stat_byte); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        rst = 1'b0;
        stat_q.push_back(8'h91);
        @(negedge clk);
        e = stat_q.pop_front();
        checks++; if (stat_valid !== 1'b1 || stat_byte !== e) begin errors++; $display("FAIL first_stat: got v=%b %h want v=1 %h", stat_valid, stat_byte, e); end
        stat_ready = 1'b1;
        @(negedge clk);
        checks++; if (stat_valid !== 1'b0) begin errors++; $display("FAIL first_accept: got v=%b want 0", stat_valid); end
    endtask

    task automatic test_forward();
        logic [10:0] ec;
        logic [7:0]  es;
        stat_ready = 1'b0; prox_level = 4'd9;
        send_frame(8'hFD, 8'h02);
        ec = cmd_q.pop_front();
        checks++; if ({cmd, motor_stat} !== ec) begin errors++; $display("FAIL fwd_cmd: got %h/%0d want %h/%0d", cmd, motor_stat, ec[10:3], ec[2:0]); end
        stat_q.push_back(8'h93);
        @(negedge clk);
        es = stat_q.pop_front();
        checks++; if (stat_valid !== 1'b1 || stat_byte !== es) begin errors++; $display("FAIL fwd_stat: got v=%b %h want v=1 %h", stat_valid, stat_byte, es); end
        stat_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bad_frame();
        send_frame(8'h00, 8'h02);
        checks++; if ({cmd, motor_stat} !== {8'h02, 3'd1}) begin errors++; $display("FAIL bad_cmd_kept: got %h/%0d want 02/1", cmd, motor_stat); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL bad_err1: got %0d want 1", err_cnt); end
        repeat (299) send_frame(8'h00, 8'h02);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL bad_err_sat: got %0d want 255", err_cnt); end
        checks++; if (cmd_q.size() != 0) begin errors++; $display("FAIL bad_no_cmd: got %0d queued want 0", cmd_q.size()); end
    endtask

    task automatic test_veto();
        logic [10:0] ec;
        logic [7:0] keys[5] = '{8'h08, 8'h04, 8'h05, 8'h06, 8'h33};
        prox_level = 4'd2;
        send_frame(8'hFD, 8'h02);
        ec = cmd_q.pop_front();
        checks++; if ({cmd, motor_stat} !== ec) begin errors++; $display("FAIL veto_block: got %h/%0d want %h/%0d", cmd, motor_stat, ec[10:3], ec[2:0]); end
        prox_level = 4'd3;
        @(negedge clk);
        checks++; if ({cmd, motor_stat} !== {8'h02, 3'd1}) begin errors++; $display("FAIL veto_release: got %h/%0d want 02/1", cmd, motor_stat); end
        prox_level = 4'd2;
        @(negedge clk);
        checks++; if ({cmd, motor_stat} !== {8'h10, 3'd3}) begin errors++; $display("FAIL veto_drive_block: got %h/%0d want 10/3", cmd, motor_stat); end
        prox_level = 4'd0;
        foreach (keys[i]) begin
            send_frame(~keys[i], keys[i]);
            ec = cmd_q.pop_front();
            checks++; if ({cmd, motor_stat} !== ec) begin errors++; $display("FAIL key_%h: got %h/%0d want %h/%0d", keys[i], cmd, motor_stat, ec[10:3], ec[2:0]); end
        end
    endtask

    task automatic test_handshake();
        logic [7:0]  es;
        logic [10:0] ec;
        logic        stable = 1'b1;
        stat_ready = 1'b1; prox_level = 4'd0;
        repeat (4) @(negedge clk);
        stat_ready = 1'b0; prox_level = 4'd5;
        stat_q.push_back(8'h51);
        @(negedge clk);
        es = stat_q.pop_front();
        checks++; if (stat_valid !== 1'b1 || stat_byte !== es) begin errors++; $display("FAIL hs_offer: got v=%b %h want v=1 %h", stat_valid, stat_byte, es); end
        for (int i = 0; i < 100; i++) begin
            if (i == 30) prox_level = 4'd7;
            if (i == 60) begin
                ir_data  = {8'hFB, 8'h04, 16'h1234};
                ir_valid = 1'b1;
                cmd_q.push_back(model(8'h04, prox_level));
            end
            if (i == 61) ir_valid = 1'b0;
            @(negedge clk);
            if (stat_valid !== 1'b1 || stat_byte !== es) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL hs_stable: got unstable want %h held", es); end
        ec = cmd_q.pop_front();
        checks++; if ({cmd, motor_stat} !== ec) begin errors++; $display("FAIL hs_left: got %h/%0d want %h/%0d", cmd, motor_stat, ec[10:3], ec[2:0]); end
        stat_ready = 1'b1;
        stat_q.push_back(8'h75);
        @(negedge clk);
        checks++; if (stat_valid !== 1'b0) begin errors++; $display("FAIL hs_drop: got v=%b want 0", stat_valid); end
        @(negedge clk);
        es = stat_q.pop_front();
        checks++; if (stat_valid !== 1'b1 || stat_byte !== es) begin errors++; $display("FAIL hs_reoffer: got v=%b %h want v=1 %h", stat_valid, stat_byte, es); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        stat_ready = 1'b0; prox_level = 4'd4;
        @(negedge clk);
        checks++; if (stat_valid !== 1'b1) begin errors++; $display("FAIL rm_pending: got v=%b want 1", stat_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({cmd, motor_stat} !== 11'd0) begin errors++; $display("FAIL rm_cmd: got %h/%0d want 00/0", cmd, motor_stat); end
        checks++; if (stat_valid !== 1'b0 || stat_byte !== 8'h00) begin errors++; $display("FAIL rm_stat: got v=%b %h want v=0 00", stat_valid, stat_byte); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rm_err: got %0d want 0", err_cnt); end
        rst = 1'b0; stat_ready = 1'b1; prox_level = 4'd9;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [10:0] ec;
        send_frame(8'hF9, 8'h06);
        ec = cmd_q.pop_front();
        checks++; if ({cmd, motor_stat} !== ec) begin errors++; $display("FAIL to_right: got %h/%0d want %h/%0d", cmd, motor_stat, ec[10:3], ec[2:0]); end
        repeat (8000 - 1) @(negedge clk);
        send_frame(8'hF9, 8'h06);
        ec = cmd_q.pop_front();
        repeat (HOLD - 1) @(negedge clk);
        checks++; if ({cmd, motor_stat} !== ec) begin errors++; $display("FAIL to_reload: got %h/%0d want %h/%0d", cmd, motor_stat, ec[10:3], ec[2:0]); end
        @(negedge clk);
        checks++; if ({cmd, motor_stat} !== 11'd0) begin errors++; $display("FAIL to_idle: got %h/%0d want 00/0", cmd, motor_stat); end
    endtask

    task automatic test_collision();
        logic [10:0] ec;
        send_frame(8'hFD, 8'h02);
        ec = cmd_q.pop_front();
        repeat (HOLD - 1) @(negedge clk);
        checks++; if ({cmd, motor_stat} !== ec) begin errors++; $display("FAIL col_before: got %h/%0d want %h/%0d", cmd, motor_stat, ec[10:3], ec[2:0]); end
        send_frame(8'hFD, 8'h02);   // sampled on the expiry edge
        ec = cmd_q.pop_front();
        checks++; if ({cmd, motor_stat} !== ec) begin errors++; $display("FAIL col_win: got %h/%0d want %h/%0d", cmd, motor_stat, ec[10:3], ec[2:0]); end
        repeat (HOLD - 1) @(negedge clk);
        checks++; if ({cmd, motor_stat} !== ec) begin errors++; $display("FAIL col_hold: got %h/%0d want %h/%0d", cmd, motor_stat, ec[10:3], ec[2:0]); end
        @(negedge clk);
        checks++; if ({cmd, motor_stat} !== 11'd0) begin errors++; $display("FAIL col_idle: got %h/%0d want 00/0", cmd, motor_stat); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_bad_frame();
        test_veto();
        test_handshake();
        test_reset_mid();
        test_timeout();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
